// File: rtl/mat_result_writer_pkg.sv
// Shared types and constants for the matrix result write-back stage.
package mat_result_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    STATUS,
    DONE
  } wr_state_t;

  typedef enum logic [3:0] {
    NONE      = 4'd0,
    ADD       = 4'd1,
    SUB       = 4'd2,
    MUL       = 4'd3,
    TRANSPOSE = 4'd4
  } op_t;

  localparam int ST_NAN       = 0;
  localparam int ST_OVF       = 1;
  localparam int ST_UNF       = 2;
  localparam int ST_OVR       = 3;
  localparam int STATUS_SHIFT = 4;

  // Op/status word layout: flags sit above the 4-bit op field.
  function automatic logic [7:0] make_status_word(input logic [3:0] flags, input op_t op);
    logic [7:0] word;
    word = 8'(flags) << STATUS_SHIFT;
    word[3:0] = op;
    return word;
  endfunction

endpackage

// File: rtl/mat_result_writer_if.sv
// Result stream from the FP pipeline plus the result-memory write port.
interface mat_result_writer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);

  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic [2:0]            res_flags;
  logic                  res_ready;

  logic                  mem_ready;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    output res_valid, res_data, res_flags, mem_ready,
    input  res_ready, mem_write, mem_addr, mem_data
  );

  modport slave (
    input  res_valid, res_data, res_flags, mem_ready,
    output res_ready, mem_write, mem_addr, mem_data
  );

endinterface

// File: rtl/mat_result_writer_fifo.sv
// Registered synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mat_result_writer.sv
// Write-back stage: buffers FP results, writes them row-major to result memory,
// then writes the op/status word and pulses done.
module mat_result_writer
  import mat_result_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int RES_BASE   = 999,
  parameter int OP_ADDR    = 999
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIM_WIDTH-1:0] dim1,
  input  logic [DIM_WIDTH-1:0] dim2,
  mat_result_writer_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           status
);

  localparam logic [ADDR_WIDTH-1:0] RES_BASE_A = ADDR_WIDTH'(RES_BASE);
  localparam logic [ADDR_WIDTH-1:0] OP_ADDR_A  = ADDR_WIDTH'(OP_ADDR);

  wr_state_t state;
  wr_state_t state_next;

  logic [2*DIM_WIDTH-1:0] product;
  logic [ADDR_WIDTH-1:0]  total_in;
  logic [ADDR_WIDTH-1:0]  total;
  logic [ADDR_WIDTH-1:0]  acc_cnt;
  logic [ADDR_WIDTH-1:0]  wr_cnt;
  logic [3:0]             status_next;
  logic [3:0]             status_snap;

  logic                   res_ready;
  logic                   mem_write;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_data;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_head;

  assign product  = (2*DIM_WIDTH)'(dim1) * (2*DIM_WIDTH)'(dim2);
  assign total_in = ADDR_WIDTH'(product);
  assign push     = bus.res_valid && res_ready;

  // No flush port is needed: a job only leaves DRAIN once every accepted element
  // has been written, so the FIFO is always empty whenever the writer is IDLE.
  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.res_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    res_ready  = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (total_in == '0) ? STATUS : DRAIN;
      end
      DRAIN: begin
        res_ready = !fifo_full && (acc_cnt < total);
        mem_write = !fifo_empty;
        mem_addr  = RES_BASE_A + wr_cnt;
        mem_data  = fifo_head;
        pop       = mem_write && bus.mem_ready;
        if (wr_cnt == total) state_next = STATUS;
      end
      STATUS: begin
        mem_write = 1'b1;
        mem_addr  = OP_ADDR_A;
        mem_data  = DATA_WIDTH'(make_status_word(status_snap, NONE));
        if (bus.mem_ready) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    status_next = status;
    if (push) begin
      status_next[ST_NAN] = status[ST_NAN] | bus.res_flags[0];
      status_next[ST_OVF] = status[ST_OVF] | bus.res_flags[1];
      status_next[ST_UNF] = status[ST_UNF] | bus.res_flags[2];
    end
    if (bus.res_valid && !res_ready) status_next[ST_OVR] = 1'b1;
  end

  // The status word is frozen on entry to STATUS so mem_data stays stable while the
  // write waits for mem_ready, even if late overruns keep updating the live flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      total       <= '0;
      acc_cnt     <= '0;
      wr_cnt      <= '0;
      status      <= '0;
      status_snap <= '0;
    end else if (state == IDLE && start) begin
      total       <= total_in;
      acc_cnt     <= '0;
      wr_cnt      <= '0;
      status      <= '0;
      status_snap <= '0;
    end else begin
      status <= status_next;
      if (push) acc_cnt <= acc_cnt + ADDR_WIDTH'(1);
      if (pop)  wr_cnt  <= wr_cnt + ADDR_WIDTH'(1);
      if (state == DRAIN && state_next == STATUS) status_snap <= status_next;
    end
  end

  assign bus.res_ready = res_ready;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_data  = mem_data;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_mat_result_writer.sv
// Scoreboard bench for mat_result_writer: directed jobs queue expected memory writes,
// an independent monitor checks every accepted write against the queue.
module tb_mat_result_writer;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int DIMW = 6;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [DIMW-1:0] dim1;
  logic [DIMW-1:0] dim2;
  logic            busy;
  logic            done;
  logic [3:0]      status;

  wr_t exp_q[$];
  int  total_checks = 0;
  int  bad_checks   = 0;

  logic [31:0] fvals [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000, 32'h40C00000};

  mat_result_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mat_result_writer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DIM_WIDTH  (DIMW),
    .FIFO_DEPTH (8),
    .RES_BASE   (999),
    .OP_ADDR    (999)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .dim1   (dim1),
    .dim2   (dim2),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .status (status)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_write(input int addr, input logic [31:0] data);
    wr_t e;
    e.addr = AW'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic start_job(input int d1, input int d2);
    dim1  = DIMW'(d1);
    dim2  = DIMW'(d2);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] data, input logic [2:0] flags);
    bus.res_valid = 1'b1;
    bus.res_data  = data;
    bus.res_flags = flags;
    tick();
  endtask

  task automatic idle_inputs();
    bus.res_valid = 1'b0;
    bus.res_flags = 3'b000;
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    int found;
    found = 0;
    for (int i = 0; i < max_cycles && found == 0; i++) begin
      if (done) found = 1;
      else tick();
    end
    check_output(name, 64'(found), 64'd1);
    if (found != 0) begin
      tick();
      check_output({name, "_pulse_end"}, 64'(done), 64'd0);
      check_output({name, "_busy_low"}, 64'(busy), 64'd0);
    end
  endtask

  always @(negedge clock) begin
    wr_t e;
    if (!reset && bus.mem_write && bus.mem_ready) begin
      if (exp_q.size() == 0) begin
        total_checks++;
        bad_checks++;
        $display("[TB] FAIL unexpected_write: addr %0d data %0h, none expected", bus.mem_addr, bus.mem_data);
      end else begin
        e = exp_q.pop_front();
        check_output("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
        check_output("wr_data", 64'(bus.mem_data), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    dim1          = '0;
    dim2          = '0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.res_flags = 3'b000;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_status", 64'(status), 64'd0);
    check_output("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check_output("rst_res_ready", 64'(bus.res_ready), 64'd0);
    check_output("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] basic 2x3 job");
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) expect_write(999 + k, fvals[k]);
    expect_write(999, 32'h0);
    start_job(2, 3);
    check_output("t1_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 6; k++) apply_stimulus(fvals[k], 3'b000);
    idle_inputs();
    wait_done(20, "t1_done");
    check_output("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    check_output("t1_status", 64'(status), 64'd0);

    $display("[TB] backpressure 4x4 job");
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 8; k++) expect_write(999 + k, 32'h100 + k);
    for (int k = 0; k < 8; k++) expect_write(1007 + k, 32'h200 + k);
    expect_write(999, 32'h80);
    start_job(4, 4);
    for (int k = 0; k < 10; k++) apply_stimulus(32'h100 + k, 3'b000);
    idle_inputs();
    check_output("t2_ready_low_full", 64'(bus.res_ready), 64'd0);
    check_output("t2_overrun", 64'(status), 64'h8);
    repeat (10) tick();
    bus.mem_ready = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) apply_stimulus(32'h200 + k, 3'b000);
    idle_inputs();
    wait_done(40, "t2_done");
    check_output("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] zero-size job");
    expect_write(999, 32'h0);
    start_job(0, 5);
    wait_done(3, "t3_done");
    check_output("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] flags 1x2 job");
    expect_write(999, 32'h3F800000);
    expect_write(1000, 32'h7F800000);
    expect_write(999, 32'h20);
    start_job(1, 2);
    apply_stimulus(32'h3F800000, 3'b000);
    apply_stimulus(32'h7F800000, 3'b010);
    idle_inputs();
    wait_done(20, "t4_done");
    check_output("t4_status", 64'(status), 64'h2);
    check_output("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] extra result 1x1 job");
    expect_write(999, 32'h11111111);
    expect_write(999, 32'h80);
    start_job(1, 1);
    apply_stimulus(32'h11111111, 3'b000);
    apply_stimulus(32'h22222222, 3'b001);
    idle_inputs();
    wait_done(20, "t5_done");
    check_output("t5_status", 64'(status), 64'h8);
    check_output("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] reset mid-job 3x3");
    for (int k = 0; k < 3; k++) expect_write(999 + k, 32'hA0 + k);
    start_job(3, 3);
    for (int k = 0; k < 4; k++) apply_stimulus(32'hA0 + k, 3'b000);
    idle_inputs();
    check_output("t6_three_writes", 64'(exp_q.size()), 64'd0);
    reset = 1'b1;
    #1;
    check_output("t6_rst_mem_write", 64'(bus.mem_write), 64'd0);
    check_output("t6_rst_busy", 64'(busy), 64'd0);
    check_output("t6_rst_done", 64'(done), 64'd0);
    check_output("t6_rst_res_ready", 64'(bus.res_ready), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    expect_write(999, 32'hCAFEF00D);
    expect_write(999, 32'h0);
    start_job(1, 1);
    apply_stimulus(32'hCAFEF00D, 3'b000);
    idle_inputs();
    wait_done(20, "t6_done");
    check_output("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
